// File: rtl/l1_dcache_param.sv
// rtl/l1_dcache_param.sv - parametrised write-back, write-allocate set-associative L1 data cache
module l1_dcache_param #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int LINE_BYTES = 64,
    parameter int SETS       = 64,
    parameter int WAYS       = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cpu_req,
    output logic                      cpu_ready,
    input  logic                      cpu_we,
    input  logic                      cpu_flush,
    input  logic [ADDR_W-1:0]         cpu_addr,
    input  logic [DATA_W-1:0]         cpu_wdata,
    output logic                      cpu_resp_valid,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic                      cpu_hit,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [LINE_BYTES*8-1:0]   mem_wdata,
    input  logic                      mem_ack,
    input  logic [LINE_BYTES*8-1:0]   mem_rdata
);

    localparam int LINE_W     = LINE_BYTES * 8;
    localparam int WORD_BYTES = DATA_W / 8;
    localparam int WB_BITS    = $clog2(WORD_BYTES);
    localparam int OFF_BITS   = $clog2(LINE_BYTES);
    localparam int IDX_BITS   = $clog2(SETS);
    localparam int TAG_BITS   = ADDR_W - OFF_BITS - IDX_BITS;
    localparam int WORDS      = LINE_BYTES / WORD_BYTES;
    localparam int WSEL_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITEBACK,
        S_FILL,
        S_RESP
    } state_t;

    state_t state, state_next;

    logic [LINE_W-1:0]   data_mem  [SETS][WAYS];
    logic [TAG_BITS-1:0] tag_mem   [SETS][WAYS];
    logic                valid_mem [SETS][WAYS];
    logic                dirty_mem [SETS][WAYS];
    logic [WAY_W-1:0]    rr_ptr    [SETS];

    logic [ADDR_W-1:0]   req_addr;
    logic                req_we;
    logic                req_flush;
    logic [DATA_W-1:0]   req_wdata;
    logic [WAY_W-1:0]    victim;
    logic                victim_by_ptr;
    logic                filled;
    logic [DATA_W-1:0]   rdata_q;
    logic                hit_q;

    logic [TAG_BITS-1:0] req_tag;
    logic [IDX_BITS-1:0] req_idx;
    logic [WSEL_W-1:0]   word_sel;
    logic                unused_addr_bits;

    assign req_tag          = req_addr[ADDR_W-1 -: TAG_BITS];
    assign req_idx          = req_addr[OFF_BITS +: IDX_BITS];
    assign word_sel         = (WORDS > 1) ? req_addr[WB_BITS +: WSEL_W] : '0;
    assign unused_addr_bits = ^req_addr;

    logic                lookup_hit;
    logic [WAY_W-1:0]    hit_way;
    logic                inv_found;
    logic [WAY_W-1:0]    inv_way;
    logic [WAY_W-1:0]    victim_sel;
    logic                victim_dirty;
    logic                hit_dirty;
    logic [LINE_W-1:0]   hit_line;
    logic [DATA_W-1:0]   hit_word;

    // Tag match and lowest-index invalid way are found in the same sweep of the set.
    always_comb begin
        lookup_hit = 1'b0;
        hit_way    = '0;
        inv_found  = 1'b0;
        inv_way    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!lookup_hit && valid_mem[req_idx][w] && tag_mem[req_idx][w] == req_tag) begin
                lookup_hit = 1'b1;
                hit_way    = WAY_W'(w);
            end
            if (!inv_found && !valid_mem[req_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign victim_sel   = inv_found ? inv_way : rr_ptr[req_idx];
    assign victim_dirty = valid_mem[req_idx][victim_sel] && dirty_mem[req_idx][victim_sel];
    assign hit_dirty    = dirty_mem[req_idx][hit_way];
    assign hit_line     = data_mem[req_idx][hit_way];
    assign hit_word     = hit_line[word_sel*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (cpu_req) begin
                    state_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (req_flush) begin
                    state_next = (lookup_hit && hit_dirty) ? S_WRITEBACK : S_RESP;
                end else if (lookup_hit) begin
                    state_next = S_RESP;
                end else begin
                    state_next = victim_dirty ? S_WRITEBACK : S_FILL;
                end
            end
            S_WRITEBACK: begin
                if (mem_ack) begin
                    state_next = req_flush ? S_RESP : S_FILL;
                end
            end
            S_FILL: begin
                if (mem_ack) begin
                    state_next = S_LOOKUP;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cpu_ready      = (state == S_IDLE);
        cpu_resp_valid = (state == S_RESP);
        cpu_rdata      = '0;
        cpu_hit        = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        case (state)
            S_RESP: begin
                cpu_rdata = rdata_q;
                cpu_hit   = hit_q;
            end
            S_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_mem[req_idx][victim], req_idx, {OFF_BITS{1'b0}}};
                mem_wdata = data_mem[req_idx][victim];
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_idx, {OFF_BITS{1'b0}}};
            end
            default: begin
            end
        endcase
    end

    // Request context; the repeat lookup after a fill reuses it and reports the access as a miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr      <= '0;
            req_we        <= 1'b0;
            req_flush     <= 1'b0;
            req_wdata     <= '0;
            victim        <= '0;
            victim_by_ptr <= 1'b0;
            filled        <= 1'b0;
            rdata_q       <= '0;
            hit_q         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        req_addr  <= cpu_addr;
                        req_we    <= cpu_we;
                        req_flush <= cpu_flush;
                        req_wdata <= cpu_wdata;
                        filled    <= 1'b0;
                    end
                end
                S_LOOKUP: begin
                    victim        <= req_flush ? hit_way : victim_sel;
                    victim_by_ptr <= !req_flush && !inv_found;
                    rdata_q       <= (lookup_hit && !req_we && !req_flush) ? hit_word : '0;
                    hit_q         <= req_flush ? lookup_hit : (lookup_hit && !filled);
                end
                S_FILL: begin
                    if (mem_ack) begin
                        filled <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                rr_ptr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_mem[s][w] <= 1'b0;
                    dirty_mem[s][w] <= 1'b0;
                end
            end
        end else begin
            case (state)
                S_LOOKUP: begin
                    if (lookup_hit && req_flush && !hit_dirty) begin
                        valid_mem[req_idx][hit_way] <= 1'b0;
                    end else if (lookup_hit && req_we && !req_flush) begin
                        dirty_mem[req_idx][hit_way] <= 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack) begin
                        dirty_mem[req_idx][victim] <= 1'b0;
                        if (req_flush) begin
                            valid_mem[req_idx][victim] <= 1'b0;
                        end
                    end
                end
                S_FILL: begin
                    if (mem_ack) begin
                        valid_mem[req_idx][victim] <= 1'b1;
                        dirty_mem[req_idx][victim] <= 1'b0;
                        if (victim_by_ptr && WAYS > 1) begin
                            rr_ptr[req_idx] <= rr_ptr[req_idx] + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Line contents and tags are deliberately left out of reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (state == S_FILL && mem_ack) begin
            data_mem[req_idx][victim] <= mem_rdata;
            tag_mem[req_idx][victim]  <= req_tag;
        end else if (state == S_LOOKUP && lookup_hit && req_we && !req_flush) begin
            data_mem[req_idx][hit_way][word_sel*DATA_W +: DATA_W] <= req_wdata;
        end
    end

endmodule

// File: doc/l1_dcache_param.md
# l1_dcache_param

Parametrised, write-back, write-allocate set-associative L1 data cache for the i7-style hierarchy. It generalises the fixed 64-set, 8-way, 64-byte L1_D into configurable geometry. It adds a full lookup/miss/eviction state machine, round-robin replacement, dirty-line writeback and a line-flush operation. It sits between the CPU-side request port and the next cache level (L2), which it reaches over a line-wide request/acknowledge port.

## Interface
- ADDR_W, 64, byte address width
- DATA_W, 64, CPU word width in bits; power of two, 8..LINE_BYTES*8
- LINE_BYTES, 64, line size in bytes; power of two
- SETS, 64, number of sets; power of two, >=2
- WAYS, 8, associativity; power of two, >=1
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  request valid; held until accepted
- cpu_ready  out  1  high only in IDLE; request accepted when cpu_req && cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_flush  in  1  1 = flush the line containing cpu_addr (overrides cpu_we)
- cpu_addr  in  ADDR_W  byte address; low log2(DATA_W/8) bits ignored
- cpu_wdata  in  DATA_W  write data
- cpu_resp_valid  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid with cpu_resp_valid; 0 for writes and flushes
- cpu_hit  out  1  valid with cpu_resp_valid; 1 = request hit without a fill
- mem_req  out  1  next-level request; held until mem_ack
- mem_we  out  1  1 = line writeback, 0 = line fill
- mem_addr  out  ADDR_W  line-aligned address (offset bits zero)
- mem_wdata  out  LINE_BYTES*8  victim line for writeback
- mem_ack  in  1  one-cycle acknowledge; mem_rdata valid in the same cycle for fills
- mem_rdata  in  LINE_BYTES*8  fill line

## Operation
- Address split: offset = log2(LINE_BYTES) LSBs; index = next log2(SETS) bits; tag = remaining upper bits. Word select = offset bits above log2(DATA_W/8).
- Per line: data, tag, valid, dirty. Per set: round-robin pointer of log2(WAYS) bits.
- States: IDLE, LOOKUP, WRITEBACK, FILL, RESP.
- IDLE: on accept, latch address, we, flush and wdata -> LOOKUP.
- LOOKUP: compare the tag against all ways of the set.
  - Read or write hit -> RESP. A write updates the word and sets dirty.
  - Flush hit on a dirty line -> WRITEBACK. Flush hit on a clean line: clear valid -> RESP. Flush miss -> RESP.
  - Read or write miss: choose a victim. The victim is the lowest-index invalid way; if every way is valid, it is the way at the round-robin pointer. If the victim is valid and dirty -> WRITEBACK, otherwise -> FILL.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index, 0}, mem_wdata=victim line. On mem_ack, clear dirty. Then go to FILL for a miss, or clear valid and go to RESP for a flush.
- FILL: mem_req=1, mem_we=0, mem_addr={req tag, index, 0}. On mem_ack, write mem_rdata, tag, valid=1, dirty=0. If the victim was chosen by the pointer, the pointer increments mod WAYS. Then go to LOOKUP; the repeated lookup hits and completes the access with cpu_hit=0.
- RESP: cpu_resp_valid=1 for one cycle with cpu_rdata and cpu_hit -> IDLE.
- cpu_hit=1 only when no FILL occurred for the request; a flush reports 1 if the line was present.

## Timing
- Reset (async, immediate): all valid and dirty bits 0, pointers 0, state IDLE. Outputs: cpu_ready=1, cpu_resp_valid=0, cpu_rdata=0, cpu_hit=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. Data and tag arrays are not cleared.
- Reset mid-miss: mem_req drops asynchronously and the transaction is abandoned. A late mem_ack is ignored.
- Hit latency: accept at edge N; cpu_resp_valid high in cycle N+2.
- Clean miss: mem_req rises at N+2. If mem_ack arrives at edge A, the response is at A+2 (LOOKUP, then RESP).
- Dirty miss: the writeback ack at W starts fill mem_req at W+1, which is low for zero cycles between the two transactions when mem_we changes. The fill ack then follows the clean-miss timing.
- mem_req, mem_we, mem_addr and mem_wdata stay stable while mem_req is high and no ack has arrived. mem_req deasserts in the cycle after mem_ack.
- cpu_ready is low from the accept edge until the cycle after RESP, giving back-to-back requests a 3-cycle minimum spacing.
- No request is accepted while cpu_resp_valid is high.

## Test plan
- Reset, then read 0x1000 with mem_rdata word0=0xAAAA -> fill at mem_addr 0x1000; cpu_rdata=0xAAAA, cpu_hit=0; repeat the read -> response 2 cycles after accept, cpu_hit=1.
- Write 0x1008=0x1234 (miss), read 0x1008 -> 0x1234, hit; no mem_req on the read.
- Fill 9 distinct tags into set 0 (addresses k*0x1000, k=0..8) with defaults -> the 9th evicts way 0 (tag 0); pointer=1; re-read 0x0 -> miss.
- Dirty eviction: write 0x0=0x55, then access 8 other set-0 tags -> one WRITEBACK with mem_addr 0x0 and word0=0x55, followed by a fill.
- Flush 0x0 while dirty -> writeback, then response with cpu_hit=1; next read of 0x0 misses. Flush of an absent line -> response at N+2, no mem_req.
- Assert rst_n=0 while FILL waits for mem_ack -> mem_req=0 immediately; after release, read of the same address misses and issues a new fill.
